// File: rtl/wram_rd_resp.sv
// rtl/wram_rd_resp.sv - weight SRAM read responder with in-order read queue and AXI write arbitration
// Reads bypass to the SRAM when idle; writes win unless the queue is full or WR_MAX grants have starved reads.
module wram_rd_resp #(
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_WIDTH  = 128,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 1,
  parameter int WR_MAX     = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          ram_read_vld_i,
  input  logic [ADDR_WIDTH-1:0]         ram_read_addr_i,
  input  logic                          rd_flush_i,
  input  logic                          wr_vld_i,
  output logic                          wr_rdy_o,
  input  logic [ADDR_WIDTH-1:0]         wr_addr_i,
  input  logic [RAM_WIDTH-1:0]          wr_data_i,
  input  logic [RAM_WIDTH/8-1:0]        wr_strb_i,
  output logic                          sram_cs_o,
  output logic                          sram_we_o,
  output logic [ADDR_WIDTH-1:0]         sram_addr_o,
  output logic [RAM_WIDTH-1:0]          sram_wdata_o,
  output logic [RAM_WIDTH-1:0]          sram_wmask_o,
  input  logic [RAM_WIDTH-1:0]          sram_rdata_i,
  output logic                          ram_buff_alloc_vld_o,
  output logic [ADDR_WIDTH-1:0]         ram_buff_alloc_addr_o,
  output logic [RAM_WIDTH-1:0]          ram_buff_alloc_data_o,
  output logic [$clog2(FIFO_DEPTH):0]   rd_fifo_cnt_o,
  output logic                          rd_busy_o
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int WCW = $clog2(WR_MAX + 1);

  typedef enum logic {WR_PRIO = 1'b0, RD_PRIO = 1'b1} arb_e;

  arb_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0] fifo_q [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [WCW-1:0]        wr_cnt_q, wr_cnt_d;
  logic [RD_LAT-1:0]     pipe_vld_q, pipe_vld_d;
  logic [ADDR_WIDTH-1:0] pipe_addr_q [RD_LAT];
  logic [ADDR_WIDTH-1:0] pipe_addr_d [RD_LAT];

  logic                  wr_grant, rd_issue, pop, push, bypass, rd_req, fifo_empty;
  logic [ADDR_WIDTH-1:0] rd_addr;

  assign fifo_empty = (cnt_q == '0);
  // A request arriving with a flush belongs to the dropped batch.
  assign rd_req     = ram_read_vld_i & ~rd_flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= WR_PRIO;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      wr_cnt_q   <= '0;
      pipe_vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_addr_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      pipe_vld_q <= pipe_vld_d;
      for (int i = 0; i < RD_LAT; i++) pipe_addr_q[i] <= pipe_addr_d[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= ram_read_addr_i;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (rd_flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
      wr_cnt_d = '0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
      if (rd_issue || fifo_empty) wr_cnt_d = '0;
      else if (wr_grant)          wr_cnt_d = wr_cnt_q + 1'b1;
    end
    if (cnt_d == CW'(FIFO_DEPTH) || (wr_cnt_d == WCW'(WR_MAX) && cnt_d != '0))
      state_d = RD_PRIO;
    else
      state_d = WR_PRIO;
  end

  always_comb begin
    wr_grant = 1'b0;
    rd_issue = 1'b0;
    pop      = 1'b0;
    bypass   = 1'b0;
    rd_addr  = '0;
    if (!rst_i) begin
      if (state_q == RD_PRIO) begin
        if (!rd_flush_i) begin
          rd_issue = 1'b1;
          pop      = 1'b1;
          rd_addr  = fifo_q[rd_ptr_q];
        end
      end else if (wr_vld_i) begin
        wr_grant = 1'b1;
      end else if (!fifo_empty && !rd_flush_i) begin
        rd_issue = 1'b1;
        pop      = 1'b1;
        rd_addr  = fifo_q[rd_ptr_q];
      end else if (fifo_empty && rd_req) begin
        rd_issue = 1'b1;
        bypass   = 1'b1;
        rd_addr  = ram_read_addr_i;
      end
    end
  end

  assign push = rd_req & ~bypass & ~rst_i;

  always_comb begin
    pipe_vld_d     = '0;
    pipe_vld_d[0]  = rd_issue;
    pipe_addr_d[0] = rd_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1] & ~rd_flush_i;
      pipe_addr_d[i] = pipe_addr_q[i-1];
    end
  end

  always_comb begin
    wr_rdy_o     = ~rst_i & (state_q == WR_PRIO);
    sram_cs_o    = wr_grant | rd_issue;
    sram_we_o    = wr_grant;
    sram_addr_o  = wr_grant ? wr_addr_i : rd_addr;
    sram_wdata_o = wr_grant ? wr_data_i : '0;
    sram_wmask_o = '0;
    for (int i = 0; i < RAM_WIDTH/8; i++)
      sram_wmask_o[8*i +: 8] = {8{wr_grant & wr_strb_i[i]}};
    // Lines already in flight when a flush arrives are suppressed at the output.
    ram_buff_alloc_vld_o  = pipe_vld_q[RD_LAT-1] & ~rst_i & ~rd_flush_i;
    ram_buff_alloc_addr_o = ram_buff_alloc_vld_o ? pipe_addr_q[RD_LAT-1] : '0;
    ram_buff_alloc_data_o = ram_buff_alloc_vld_o ? sram_rdata_i : '0;
    rd_fifo_cnt_o         = rst_i ? '0 : cnt_q;
    rd_busy_o             = ~rst_i & (~fifo_empty | (|pipe_vld_q));
  end

endmodule
